// File: rtl/ps2_rx_pkg.sv
// Shared PS/2 receiver definitions: FSM encodings, frame geometry and
// keyboard scan-code constants used by the receiver and its consumers.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    PS2_IDLE   = 2'd0,
    PS2_DATA   = 2'd1,
    PS2_PARITY = 2'd2,
    PS2_STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_FRAME_LEN = 11;
  localparam int PS2_DATA_BITS = 8;

  localparam logic [7:0] KEYBOARD_EXT   = 8'hE0;
  localparam logic [7:0] KEYBOARD_BREAK = 8'hF0;
  localparam logic [7:0] KEYBOARD_UP    = 8'h75;
  localparam logic [7:0] KEYBOARD_DOWN  = 8'h72;
  localparam logic [7:0] KEYBOARD_LEFT  = 8'h6B;
  localparam logic [7:0] KEYBOARD_RIGHT = 8'h74;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer for one PS/2 line, optionally followed by a
// FILTER_LEN-sample glitch filter and a falling-edge strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8,
  parameter bit BYPASS     = 1'b0
) (
  input  logic clk50m_i,
  input  logic rst_n_i,
  input  logic line_i,
  output logic filt_o,
  output logic fall_stb_o
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= line_i;
      sync_p1 <= sync_p0;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign filt_o     = sync_p1;
      assign fall_stb_o = 1'b0;
    end else begin : g_filter
      localparam int CW = $clog2(FILTER_LEN) + 1;
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

      logic [CW-1:0] cnt;
      logic          filt;
      logic          fall;

      // Any sample matching the current level restarts the run, so only
      // FILTER_LEN consecutive differing samples move the filtered level.
      always_ff @(posedge clk50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          cnt  <= '0;
          filt <= 1'b1;
          fall <= 1'b0;
        end else begin
          fall <= 1'b0;
          if (sync_p1 == filt) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            filt <= sync_p1;
            fall <= filt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign filt_o     = filt;
      assign fall_stb_o = fall;
    end
  endgenerate

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: rebuilds 11-bit frames from the keyboard
// lines and delivers checked bytes with a one-cycle strobe.
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk50m_i,
  input  logic       rst_n_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state;
  ps2_state_t    state_nxt;
  logic [7:0]    shift;
  logic [3:0]    bit_cnt;
  logic          parity;
  logic [TW-1:0] to_cnt;
  logic          fall_stb;
  logic          data_s;
  logic          to_hit;
  logic          frame_ok;
  logic          frame_bad;
  logic          clk_lvl_unused;
  logic          data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .BYPASS(1'b0)) u_clk_filter (
    .clk50m_i  (clk50m_i),
    .rst_n_i   (rst_n_i),
    .line_i    (ps2_clk_i),
    .filt_o    (clk_lvl_unused),
    .fall_stb_o(fall_stb)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .BYPASS(1'b1)) u_data_sync (
    .clk50m_i  (clk50m_i),
    .rst_n_i   (rst_n_i),
    .line_i    (ps2_data_i),
    .filt_o    (data_s),
    .fall_stb_o(data_fall_unused)
  );

  // A clock edge in the expiry cycle keeps the frame alive.
  assign to_hit = (state != PS2_IDLE) && !fall_stb && (to_cnt == TO_LAST);

  always_ff @(posedge clk50m_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= PS2_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (to_hit) begin
      state_nxt = PS2_IDLE;
    end else if (fall_stb) begin
      case (state)
        PS2_IDLE:   if (!data_s) state_nxt = PS2_DATA;
        PS2_DATA:   if (bit_cnt == 4'(PS2_DATA_BITS - 1)) state_nxt = PS2_PARITY;
        PS2_PARITY: state_nxt = PS2_STOP;
        PS2_STOP:   state_nxt = PS2_IDLE;
        default:    state_nxt = PS2_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = to_hit;
    if (fall_stb && state == PS2_STOP) begin
      if (data_s && odd_parity_ok(shift, parity)) frame_ok  = 1'b1;
      else                                       frame_bad = 1'b1;
    end
  end

  always_ff @(posedge clk50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift            <= '0;
      bit_cnt          <= '0;
      parity           <= 1'b0;
      to_cnt           <= '0;
      received_data    <= '0;
      received_data_en <= 1'b0;
      frame_err_o      <= 1'b0;
    end else begin
      received_data_en <= frame_ok;
      frame_err_o      <= frame_bad;
      if (frame_ok) received_data <= shift;

      if (state == PS2_IDLE || fall_stb || to_hit) to_cnt <= '0;
      else                                         to_cnt <= to_cnt + 1'b1;

      if (fall_stb) begin
        case (state)
          PS2_IDLE: bit_cnt <= '0;
          PS2_DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PS2_PARITY: parity <= data_s;
          default: ;
        endcase
      end
    end
  end

endmodule
